// File: rtl/puf_chal_applier_pkg.sv
// Shared types and defaults for the PUF challenge applier.
package puf_chal_applier_pkg;

   localparam int unsigned CHAL_W_DEF = 64;
   localparam int unsigned RESP_W_DEF = 32;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StLaunch = 3'd1,
      StSettle = 3'd2,
      StSample = 3'd3,
      StHold   = 3'd4
   } state_e;

endpackage

// File: rtl/puf_resp_sync.sv
// Two-flop synchroniser for the raw arbiter latch output.
module puf_resp_sync (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_d,
   output logic o_q
);

   logic [1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[0], i_d};
      end
   end

   assign o_q = r_sync[1];

endmodule

// File: rtl/puf_chal_applier.sv
// Applies LFSR challenges to the arbiter PUF, samples the synchronised response after a settle
// window and packs response bits into words delivered over a valid/ready handshake.
module puf_chal_applier
   import puf_chal_applier_pkg::*;
#(
   parameter int unsigned CHAL_W = CHAL_W_DEF,
   parameter int unsigned RESP_W = RESP_W_DEF,
   parameter int unsigned SETTLE = 16,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              i_lfsrclk,
   input  logic              i_rstn,
   input  logic [CHAL_W-1:0] i_ldw,
   input  logic              i_lfsrdone,
   output logic [CHAL_W-1:0] o_chal,
   output logic              o_launch,
   input  logic              i_pufresp,
   output logic [RESP_W-1:0] o_respword,
   output logic              o_respvalid,
   input  logic              i_respready,
   output logic              o_busy,
   output logic              o_ovf
);

   localparam int unsigned      IDX_W    = $clog2(RESP_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_W - 1);

   state_e              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0]    r_idx, w_idx_nxt;
   logic [RESP_W-1:0]   r_acc, w_acc_nxt;
   logic [CHAL_W-1:0]   r_chal, w_chal_nxt;
   logic                r_launch, w_launch_nxt;
   logic [RESP_W-1:0]   r_respword, w_respword_nxt;
   logic                r_respvalid, w_respvalid_nxt;
   logic                r_ovf, w_ovf_nxt;
   logic                w_sync;
   logic                w_out_free;

   puf_resp_sync u_resp_sync (
      .i_clk  (i_lfsrclk),
      .i_rstn (i_rstn),
      .i_d    (i_pufresp),
      .o_q    (w_sync)
   );

   // Output register can take a new word if empty or being drained on this edge.
   assign w_out_free = ~r_respvalid | i_respready;

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_idx_nxt       = r_idx;
      w_acc_nxt       = r_acc;
      w_chal_nxt      = r_chal;
      w_launch_nxt    = 1'b0;
      w_respword_nxt  = r_respword;
      w_respvalid_nxt = r_respvalid & ~i_respready;
      w_ovf_nxt       = r_ovf | (i_lfsrdone & (r_state != StIdle));

      unique case (r_state)
         StIdle: begin
            if (i_lfsrdone) begin
               w_chal_nxt   = i_ldw;
               w_launch_nxt = 1'b1;
               w_state_nxt  = StLaunch;
            end
         end
         StLaunch: begin
            w_cnt_nxt   = '0;
            w_state_nxt = StSettle;
         end
         StSettle: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = StSample;
            end
         end
         StSample: begin
            w_acc_nxt[r_idx] = w_sync;
            if (r_idx != IDX_LAST) begin
               w_idx_nxt   = r_idx + 1'b1;
               w_state_nxt = StIdle;
            end else if (w_out_free) begin
               w_respword_nxt  = {w_sync, r_acc[RESP_W-2:0]};
               w_respvalid_nxt = 1'b1;
               w_idx_nxt       = '0;
               w_state_nxt     = StIdle;
            end else begin
               w_state_nxt = StHold;
            end
         end
         StHold: begin
            if (w_out_free) begin
               w_respword_nxt  = r_acc;
               w_respvalid_nxt = 1'b1;
               w_idx_nxt       = '0;
               w_state_nxt     = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge i_lfsrclk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_acc       <= '0;
         r_chal      <= '0;
         r_launch    <= 1'b0;
         r_respword  <= '0;
         r_respvalid <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_idx       <= w_idx_nxt;
         r_acc       <= w_acc_nxt;
         r_chal      <= w_chal_nxt;
         r_launch    <= w_launch_nxt;
         r_respword  <= w_respword_nxt;
         r_respvalid <= w_respvalid_nxt;
         r_ovf       <= w_ovf_nxt;
      end
   end

   assign o_chal      = r_chal;
   assign o_launch    = r_launch;
   assign o_respword  = r_respword;
   assign o_respvalid = r_respvalid;
   assign o_busy      = (r_state != StIdle);
   assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_puf_chal_applier.sv
// Self-checking bench for puf_chal_applier: timer-based behavioural model plus directed vectors.
module tb_puf_chal_applier;

   localparam int unsigned CHAL_W = 64;
   localparam int unsigned RESP_W = 32;
   localparam int unsigned SETTLE = 16;
   localparam int unsigned CNT_W  = 8;
   localparam logic [63:0] T1W    = 64'hCDB5_A559_AB83_F00A;
   localparam logic [63:0] T4A    = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] T4B    = 64'hFEDC_BA98_7654_3210;

   logic              clk, rstn, lfsrdone, pufresp, respready;
   logic [CHAL_W-1:0] ldw, o_chal;
   logic [RESP_W-1:0] o_respword;
   logic              o_launch, o_respvalid, o_busy, o_ovf;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int n0;
   bit jitter = 0;

   // Model state: an accepted strobe starts a timer; the sample lands SETTLE+2 edges later.
   bit                m_active, m_pend, m_valid, m_ovf, ph1, ph2, free, sbit;
   int                m_t, m_n;
   logic [CHAL_W-1:0] m_chal;
   logic [RESP_W-1:0] m_acc, m_word;

   puf_chal_applier #(
      .CHAL_W (CHAL_W),
      .RESP_W (RESP_W),
      .SETTLE (SETTLE),
      .CNT_W  (CNT_W)
   ) dut (
      .i_lfsrclk   (clk),
      .i_rstn      (rstn),
      .i_ldw       (ldw),
      .i_lfsrdone  (lfsrdone),
      .o_chal      (o_chal),
      .o_launch    (o_launch),
      .i_pufresp   (pufresp),
      .o_respword  (o_respword),
      .o_respvalid (o_respvalid),
      .i_respready (respready),
      .o_busy      (o_busy),
      .o_ovf       (o_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn) begin
            m_active = 0; m_pend = 0; m_valid = 0; m_ovf = 0; ph1 = 0; ph2 = 0;
            m_t = 0; m_n = 0; m_chal = '0; m_acc = '0; m_word = '0;
         end else begin
            cyc++;
            free = !m_valid || respready;
            if (m_valid && respready) m_valid = 0;
            sbit = ph2; ph2 = ph1; ph1 = pufresp;
            if (!m_active) begin
               if (lfsrdone) begin m_active = 1; m_t = 0; m_chal = ldw; end
            end else begin
               if (lfsrdone) m_ovf = 1;
               if (m_pend) begin
                  if (free) begin
                     m_word = m_acc; m_valid = 1; m_pend = 0; m_active = 0; m_n = 0;
                  end
               end else begin
                  m_t++;
                  if (m_t == int'(SETTLE) + 2) begin
                     m_acc[m_n] = sbit;
                     m_n++;
                     if (m_n == int'(RESP_W)) begin
                        if (free) begin
                           m_word = m_acc; m_valid = 1; m_n = 0; m_active = 0;
                        end else m_pend = 1;
                     end else m_active = 0;
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rstn) begin
         chk("chal", o_chal, m_chal);
         chk("launch", 64'(o_launch), 64'(m_active && !m_pend && m_t == 0));
         chk("busy", 64'(o_busy), 64'(m_active));
         chk("ovf", 64'(o_ovf), 64'(m_ovf));
         chk("respvalid", 64'(o_respvalid), 64'(m_valid));
         if (m_valid) chk("respword", 64'(o_respword), 64'(m_word));
      end
   end

   function automatic logic [63:0] mk(input int i);
      return 64'(i + 1) * 64'h9E37_79B9_7F4A_7C15;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (jitter) begin
         #($urandom_range(0, 7));
         pufresp = ~pufresp;
      end
   endtask

   task automatic gap(input int n);
      repeat (n) tick();
   endtask

   task automatic strobe(input logic [63:0] w);
      ldw = w;
      lfsrdone = 1'b1;
      tick();
      lfsrdone = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0; lfsrdone = 1'b0; respready = 1'b1; jitter = 0;
      #1;
      chk("rst_chal", o_chal, 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_valid", 64'(o_respvalid), 64'd0);
      chk("rst_ovf", 64'(o_ovf), 64'd0);
      tick();
      tick();
      rstn = 1'b1;
   endtask

   task automatic wait_valid(input string name, input int bound);
      int k = 0;
      @(negedge clk);
      while (!o_respvalid && k < bound) begin
         @(negedge clk);
         k++;
      end
      chk(name, 64'(o_respvalid), 64'd1);
   endtask

   initial begin
      rstn = 1'b0; lfsrdone = 1'b0; ldw = '0; pufresp = 1'b0; respready = 1'b1;

      // Single strobe: capture, one-cycle launch, sample at edge N+18.
      do_reset();
      strobe(T1W);
      n0 = cyc;
      @(negedge clk);
      chk("t1_launch_hi", 64'(o_launch), 64'd1);
      chk("t1_chal", o_chal, T1W);
      tick();
      @(negedge clk);
      chk("t1_launch_lo", 64'(o_launch), 64'd0);
      while (cyc < n0 + 17) tick();
      @(negedge clk);
      chk("t1_busy_before_sample", 64'(o_busy), 64'd1);
      tick();
      @(negedge clk);
      chk("t1_idle_after_sample", 64'(o_busy), 64'd0);

      // 32 strobes, alternating response.
      do_reset();
      for (int i = 0; i < 32; i++) begin
         pufresp = i[0];
         strobe(mk(i));
         if (i < 31) gap(63);
      end
      wait_valid("t2_valid", 40);
      chk("t2_word", 64'(o_respword), 64'hAAAA_AAAA);
      @(negedge clk);
      chk("t2_valid_one_cycle", 64'(o_respvalid), 64'd0);

      // Back-pressure: word 1 held, word 2 parked, extra strobes dropped.
      do_reset();
      respready = 1'b0;
      for (int i = 0; i < 64; i++) begin
         pufresp = (i < 32) ? 1'b1 : (i < 48);
         strobe(mk(i));
         gap(63);
      end
      @(negedge clk);
      chk("t3_word1_held", 64'(o_respword), 64'hFFFF_FFFF);
      chk("t3_hold_busy", 64'(o_busy), 64'd1);
      chk("t3_no_ovf_yet", 64'(o_ovf), 64'd0);
      for (int i = 0; i < 2; i++) begin
         strobe(mk(100 + i));
         gap(20);
      end
      @(negedge clk);
      chk("t3_ovf", 64'(o_ovf), 64'd1);
      chk("t3_chal_kept", o_chal, mk(63));
      respready = 1'b1;
      tick();
      respready = 1'b0;
      @(negedge clk);
      chk("t3_word2", 64'(o_respword), 64'h0000_FFFF);
      chk("t3_word2_valid", 64'(o_respvalid), 64'd1);
      chk("t3_idle_after_drain", 64'(o_busy), 64'd0);
      respready = 1'b1;
      tick();
      @(negedge clk);
      chk("t3_drained", 64'(o_respvalid), 64'd0);

      // Strobe 5 clocks after an accepted one is dropped.
      do_reset();
      strobe(T4A);
      gap(4);
      strobe(T4B);
      @(negedge clk);
      chk("t4_ovf", 64'(o_ovf), 64'd1);
      chk("t4_chal", o_chal, T4A);
      gap(30);

      // Reset mid-settle discards the partial word.
      do_reset();
      pufresp = 1'b1;
      for (int i = 0; i < 10; i++) begin
         strobe(mk(i));
         gap(63);
      end
      strobe(mk(10));
      gap(8);
      chk("t5_busy_before_rst", 64'(o_busy), 64'd1);
      rstn = 1'b0;
      #1;
      chk("t5_rst_chal", o_chal, 64'd0);
      chk("t5_rst_launch", 64'(o_launch), 64'd0);
      chk("t5_rst_busy", 64'(o_busy), 64'd0);
      chk("t5_rst_valid", 64'(o_respvalid), 64'd0);
      chk("t5_rst_word", 64'(o_respword), 64'd0);
      chk("t5_rst_ovf", 64'(o_ovf), 64'd0);
      tick();
      rstn = 1'b1;
      for (int i = 0; i < 32; i++) begin
         pufresp = (i >= 16);
         strobe(mk(i));
         if (i < 31) gap(63);
      end
      wait_valid("t5_valid", 40);
      chk("t5_fresh_word", 64'(o_respword), 64'hFFFF_0000);

      // Response toggling at random points within each cycle.
      do_reset();
      jitter = 1;
      for (int i = 0; i < 32; i++) begin
         strobe(mk(i));
         if (i < 31) gap(63);
      end
      wait_valid("t6_valid", 40);
      jitter = 0;
      gap(4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
